fe_mul: RTL and testbench
=========================

# fe_mul

Multi-cycle multiplier over GF(2^255−19) for the curve25519 datapath. Accepts two 255-bit operands in any representation (values ≥ p allowed). Returns the fully reduced product a·b mod p, with p = 2^255−19. Uses a start/done handshake, one digit-serial pass, then final folding and freezing.

## Interface
- Parameters:
  - DIGIT_W, default 17: bits of b consumed per cycle; must divide 255.
- Ports:
  - clock  in  1: rising-edge clock.
  - reset_n  in  1: reset, synchronous, active-low.
  - start  in  1: one-cycle request; a and b are sampled on the same edge.
  - a  in  255: multiplicand; any value 0 to 2^255−1.
  - b  in  255: multiplier; any value 0 to 2^255−1.
  - done  out  1: one-cycle pulse; out is valid in this cycle.
  - out  out  255: product mod p, always < p.
- Reset is synchronous and active-low. Clock and reset are named clock and reset_n.

## Operation
- States:
  - IDLE: waiting for start.
  - MUL: 255/DIGIT_W cycles.
  - FOLD: one cycle.
  - FREEZE: one cycle.
  - IDLE again, with done pulsed on that edge.
- On start, latch a into areg and b into breg, then clear the accumulator.
- MUL step: take digit d = top DIGIT_W bits of breg (MSB-first), then shift breg left by DIGIT_W.
  - partial = (acc << DIGIT_W) + areg·d, 273 bits wide.
  - carry = partial[272:255].
  - acc ← partial[254:0] + 19·carry, because 2^255 ≡ 19 mod p.
  - acc is 256 bits wide.
- FOLD: acc ← acc[254:0] + 19·acc[255]. The result is < 2^255.
- FREEZE: partialP = acc − p, 256 bits wide.
  - borrow = partialP[255].
  - wrapP = !borrow.
  - out ← wrapP ? partialP[254:0] : acc[254:0].
- Internal nets carry, partial, borrow, partialP and wrapP exist under these names for debug probing.
- out holds its value until the next done. It is not cleared by start.

## Timing
- Reset values: done=0, out=0, state IDLE, accumulator 0.
- Latency: done is high in the cycle 255/DIGIT_W + 2 edges after the start edge (17 edges for DIGIT_W=17).
- done is high for exactly one cycle.
- start is accepted in the same cycle done is high, and in IDLE.
- start while busy aborts the current operation and restarts with the new operands. No done is issued for the aborted operation.
- reset_n low mid-operation returns to IDLE next edge; no done is issued.
- Back-to-back: start may be asserted on the edge right after done. Throughput is one result per 18 cycles.

## Configuration
- FEMUL_ASSERT_EN:
  - Defined: simulation-only checks.
    - out < p whenever done=1.
    - done never high on two consecutive cycles.
    - No X on out when done=1.
    - Failures call $error.
  - Undefined: checks are not compiled; RTL is identical.

## Structure
- Package fe_pkg holds:
  - FE_W=255.
  - FE_P = 2^255−19.
  - FE_FOLD=19.
  - typedef fe_t as logic [254:0].
  - The state enum.
- One natural sub-module, fe_freeze: combinational FOLD/FREEZE logic (256-bit in, reduced 255-bit out, borrow/wrapP). The digit-serial loop stays in fe_mul.

## Test plan
- a = 2^128, b = 2^128 → out = 0x26.
- a = 2^255−1, b = 1 → out = 0x12. Checks that a non-reduced input gets frozen.
- a = 2^128−1, b = 2^128+1 → out = 0x25.
- a = 2^254, b = 2 → out = 19.
- a = 0x6483b328032df78f6abb1342dc54964127be97507e17c1b4cf481339f1fa20de, b = 0xb47d26181c9f63bb1405345faca4ffd0fe748b6652fa7d2decf0e2c865e988d → out = 0x7587e6935be3c0628e7fa76da3931343283adb49a03f048998eb0f9b51a209ef.
- Protocol checks:
  - Back-to-back starts: done appears exactly 17 cycles after each start.
  - start mid-computation restarts the operation.
  - reset_n low mid-operation: no done, out = 0.

Source files
------------

// File: rtl/fe_pkg.sv
// Shared constants and types for the GF(2^255-19) multiplier.
// Field width, modulus, fold constant (2^255 = 19 mod p) and the controller state enum.
package fe_pkg;

    localparam int unsigned FE_W    = 255;
    localparam int unsigned ACC_W   = FE_W + 1;
    localparam int unsigned FE_FOLD = 19;

    typedef logic [FE_W-1:0] fe_t;

    localparam fe_t FE_ONES = '1;
    localparam fe_t FE_P    = FE_ONES - fe_t'(FE_FOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_FOLD,
        ST_FREEZE
    } fe_state_e;

endpackage

// File: rtl/fe_freeze.sv
// Combinational final reduction: fold bit 255 back in as 19, then freeze into [0, p).
// Both results are computed from the same accumulator; the controller picks which one to load.
module fe_freeze
    import fe_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0] fold_o,
    output fe_t              freeze_o
);

    logic [ACC_W-1:0] partialP;
    logic             borrow;
    logic             wrapP;

    always_comb begin
        fold_o   = {1'b0, acc_i[FE_W-1:0]} + (acc_i[FE_W] ? ACC_W'(FE_FOLD) : '0);
        // Input is already folded (< 2^255 < 2p), so one conditional subtract suffices.
        partialP = acc_i - {1'b0, FE_P};
        borrow   = partialP[FE_W];
        wrapP    = !borrow;
        freeze_o = wrapP ? partialP[FE_W-1:0] : acc_i[FE_W-1:0];
    end

endmodule

// File: rtl/fe_mul.sv
// Digit-serial a*b mod (2^255-19): MSB-first digits of b, per-step fold, then FOLD and FREEZE.
// Optional simulation checks on the result are compiled when FEMUL_ASSERT_EN is defined.
module fe_mul
    import fe_pkg::*;
#(
    parameter int unsigned DIGIT_W = 17
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic         done,
    output logic [254:0] out
);

    localparam int unsigned NDIG   = FE_W / DIGIT_W;
    localparam int unsigned PART_W = FE_W + DIGIT_W + 1;
    localparam int unsigned CNT_W  = $clog2(NDIG + 1);

    fe_state_e        state_q, state_d;
    fe_t              areg_q, areg_d;
    fe_t              breg_q, breg_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fe_t              out_q, out_d;
    logic             done_q, done_d;

    logic [DIGIT_W-1:0] digit;
    logic [PART_W-1:0]  partial;
    logic [DIGIT_W:0]   carry;
    logic [ACC_W-1:0]   mul_acc;
    logic [ACC_W-1:0]   fold_acc;
    fe_t                freeze_out;

    fe_freeze u_freeze (
        .acc_i    (acc_q),
        .fold_o   (fold_acc),
        .freeze_o (freeze_out)
    );

    always_comb begin
        digit   = breg_q[FE_W-1 -: DIGIT_W];
        partial = {acc_q, {DIGIT_W{1'b0}}} + PART_W'(areg_q) * PART_W'(digit);
        carry   = partial[PART_W-1:FE_W];
        mul_acc = ACC_W'(partial[FE_W-1:0]) + ACC_W'(carry) * ACC_W'(FE_FOLD);
    end

    always_comb begin
        state_d = state_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;

        case (state_q)
            ST_MUL: begin
                acc_d  = mul_acc;
                breg_d = breg_q << DIGIT_W;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                acc_d   = fold_acc;
                state_d = ST_FREEZE;
            end
            ST_FREEZE: begin
                out_d   = freeze_out;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: ;
        endcase

        // start wins in every state: a busy operation is dropped without a done.
        if (start) begin
            areg_d  = a;
            breg_d  = b;
            acc_d   = '0;
            cnt_d   = '0;
            out_d   = out_q;
            done_d  = 1'b0;
            state_d = ST_MUL;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign out  = out_q;

`ifdef FEMUL_ASSERT_EN
    a_out_reduced: assert property (@(posedge clock) done_q |-> (out_q < FE_P))
        else $error("fe_mul: out not reduced");
    a_out_known: assert property (@(posedge clock) done_q |-> !$isunknown(out_q))
        else $error("fe_mul: X on out with done");
    a_done_pulse: assert property (@(posedge clock) disable iff (!reset_n) done_q |=> !done_q)
        else $error("fe_mul: done high on consecutive cycles");
`else
`endif

endmodule

// File: tb/tb_fe_mul.sv
// Scoreboard bench for fe_mul: driver pushes expected product and done edge, monitor pops on done.
module tb_fe_mul;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [254:0] a;
    logic [254:0] b;
    logic         done;
    logic [254:0] out;

    int checks;
    int failures;
    int edge_n;

    logic [254:0] exp_q[$];
    int           edge_q[$];

    localparam logic [254:0] P =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [254:0] PM1 =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffec;
    localparam logic [254:0] ALL1 =
        255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff;
    localparam logic [254:0] TA =
        255'h6483b328032df78f6abb1342dc54964127be97507e17c1b4cf481339f1fa20de;
    localparam logic [254:0] TB =
        255'hb47d26181c9f63bb1405345faca4ffd0fe748b6652fa7d2decf0e2c865e988d;
    localparam logic [254:0] TR =
        255'h7587e6935be3c0628e7fa76da3931343283adb49a03f048998eb0f9b51a209ef;

    fe_mul #(.DIGIT_W(17)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .done    (done),
        .out     (out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        edge_n = 0;
        forever begin
            @(posedge clock);
            edge_n++;
        end
    end

    // Monitor: every done must match the oldest outstanding request, value and timing.
    initial begin
        logic [254:0] ex;
        int           ee;
        forever begin
            @(negedge clock);
            if (reset_n && done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done out=%h required=no done", out);
                end else begin
                    ex = exp_q.pop_front();
                    ee = edge_q.pop_front();
                    if (out !== ex) begin
                        failures++;
                        $display("FAIL product out=%h required=%h", out, ex);
                    end
                    checks++;
                    if (edge_n != ee) begin
                        failures++;
                        $display("FAIL latency edge=%0d required=%0d", edge_n, ee);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [254:0] ta, input logic [254:0] tb_v,
                         input logic [254:0] ex, input bit expect_done);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (expect_done) begin
            exp_q.push_back(ex);
            edge_q.push_back(edge_n + 17);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_%s pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
            edge_q.delete();
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) break;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        checks++;
        if (done !== 1'b0 || out !== '0) begin
            failures++;
            $display("FAIL reset_state done=%b out=%h required done=0 out=0", done, out);
        end

        issue(255'd1 << 128, 255'd1 << 128, 255'h26, 1'b1);
        wait_idle("pow128_sq");
        issue(ALL1, 255'd1, 255'h12, 1'b1);
        wait_idle("unreduced_a");
        issue((255'd1 << 128) - 255'd1, (255'd1 << 128) + 255'd1, 255'h25, 1'b1);
        wait_idle("diff_squares");
        issue(255'd1 << 254, 255'd2, 255'd19, 1'b1);
        wait_idle("wrap_2_255");
        issue(TA, TB, TR, 1'b1);
        wait_idle("random_vec");
        issue(P, 255'd5, 255'd0, 1'b1);
        wait_idle("a_eq_p");
        issue(PM1, PM1, 255'd1, 1'b1);
        wait_idle("minus1_sq");
        issue(ALL1, ALL1, 255'h144, 1'b1);
        wait_idle("max_sq");
        issue(255'd0, TB, 255'd0, 1'b1);
        wait_idle("zero");

        // Back-to-back: next start is raised during the done cycle.
        issue(255'd1 << 254, 255'd2, 255'd19, 1'b1);
        wait_done();
        issue(255'd1 << 128, 255'd1 << 128, 255'h26, 1'b1);
        wait_done();
        issue(TA, TB, TR, 1'b1);
        wait_idle("back_to_back");

        // Restart mid-computation: only the second operation completes.
        issue(TA, TB, TR, 1'b0);
        repeat (6) @(posedge clock);
        #1;
        issue(ALL1, 255'd1, 255'h12, 1'b1);
        wait_idle("restart");

        // Reset mid-operation: no done and out cleared.
        issue(TA, TB, TR, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b0 || out !== '0) begin
            failures++;
            $display("FAIL reset_midop done=%b out=%h required done=0 out=0", done, out);
        end
        reset_n = 1'b1;
        repeat (25) @(posedge clock);
        #1;
        checks++;
        if (out !== '0) begin
            failures++;
            $display("FAIL reset_hold out=%h required=0", out);
        end

        issue(255'd1 << 254, 255'd2, 255'd19, 1'b1);
        wait_idle("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
